add_sequencer: RTL and testbench

- Multi-cycle controller for wide integer add/subtract of 16*WORDS-bit operands.
- Sequences one shared full_adder_16 instance over successive 16-bit slices, least significant first, chaining carry through a register.
- Sits between a requester (valid/ready) and a consumer (valid/ready).
- Target use: the CPU's wide arithmetic and address paths, which need wide adds without replicating adders.

---
 rtl/add_seq_pkg.sv | 15 +
 rtl/full_adder_16.sv | 12 +
 rtl/add_sequencer.sv | 105 ++++++++++
 tb/tb_add_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and constants for the wide add/subtract sequencer
package add_seq_pkg;

  localparam int SLICE_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/full_adder_16.sv
// rtl/full_adder_16.sv - 16-bit adder slice with carry in and carry out
module full_adder_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'd0, i_cin};

endmodule

// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - multi-cycle wide add/subtract built from one shared 16-bit adder slice
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_sub,
  input  logic [SLICE_W*WORDS-1:0]   req_a,
  input  logic [SLICE_W*WORDS-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SLICE_W*WORDS-1:0]   rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf,
  output logic                       busy
);

  localparam int DATA_W = SLICE_W * WORDS;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_e          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_sum;
  logic                r_cout;
  logic                r_ovf;

  logic [SLICE_W-1:0]  w_slice_a;
  logic [SLICE_W-1:0]  w_slice_b;
  logic [SLICE_W-1:0]  w_slice_sum;
  logic                w_slice_cout;
  logic                w_accept;

  assign w_slice_a = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_slice_b = r_b[int'(r_idx)*SLICE_W +: SLICE_W];

  full_adder_16 u_adder (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            r_a     <= req_a;
            r_b     <= (req_sub == OP_ADD) ? req_b : ~req_b;
            r_carry <= (req_sub == OP_SUB);
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*SLICE_W +: SLICE_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                       (w_slice_sum[SLICE_W-1] != r_a[DATA_W-1]);
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// tb/tb_add_sequencer.sv - directed self-checking bench for add_sequencer (WORDS=4 and WORDS=1)
module tb_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_sub = 1'b0;
  logic [63:0] req_a = '0, req_b = '0, rsp_sum;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_ovf, busy;

  logic        req_valid_1 = 1'b0, req_ready_1, req_sub_1 = 1'b0;
  logic [15:0] req_a_1 = '0, req_b_1 = '0, rsp_sum_1;
  logic        rsp_valid_1, rsp_ready_1 = 1'b0, rsp_cout_1, rsp_ovf_1, busy_1;

  int n_checks = 0;
  int n_errors = 0;
  int accepts_1 = 0;

  always #5 clk = ~clk;

  add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_sub(req_sub_1),
    .req_a(req_a_1), .req_b(req_b_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_sum(rsp_sum_1),
    .rsp_cout(rsp_cout_1), .rsp_ovf(rsp_ovf_1), .busy(busy_1)
  );

  always @(posedge clk) begin
    if (req_valid_1 && req_ready_1) accepts_1 <= accepts_1 + 1;
  end

  typedef struct {
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs4[8];
  vec_t vecs1[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic run_op4(input logic sub, input logic [63:0] a, input logic [63:0] b,
                         output int lat);
    int guard;
    guard = 0;
    req_sub = sub; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait4", 64'(guard < 20), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume4();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_drop4", 64'(rsp_valid), 64'd0);
    chk("ready_idle4", 64'(req_ready), 64'd1);
  endtask

  task automatic run_op1(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
    int guard;
    guard = 0;
    req_sub_1 = sub; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
    while (!req_ready_1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait1", 64'(guard < 20), 64'd1);
    @(negedge clk);
    req_valid_1 = 1'b0;
    lat = 0;
    while (!rsp_valid_1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int acc_before;

    vecs4[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
    vecs4[1] = '{1'b1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs4[2] = '{1'b1, 64'h7, 64'h5, 64'h2, 1'b1, 1'b0};
    vecs4[3] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs4[4] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs4[5] = '{1'b0, 64'h0000_0001_FFFF_0000, 64'h0000_0000_0001_0000,
                 64'h0000_0002_0000_0000, 1'b0, 1'b0};
    vecs4[6] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1};
    vecs4[7] = '{1'b1, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0};

    vecs1[0] = '{1'b0, 64'hFFFF, 64'h0001, 64'h0000, 1'b1, 1'b0};
    vecs1[1] = '{1'b1, 64'h0003, 64'h0005, 64'hFFFE, 1'b0, 1'b0};
    vecs1[2] = '{1'b0, 64'h7FFF, 64'h0001, 64'h8000, 1'b0, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", rsp_sum, 64'd0);
    chk("rst_cout", 64'(rsp_cout), 64'd0);
    chk("rst_ovf", 64'(rsp_ovf), 64'd0);
    chk("rst_sum1", 64'(rsp_sum_1), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    // Table of WORDS=4 operations
    for (int i = 0; i < 8; i++) begin
      run_op4(vecs4[i].sub, vecs4[i].a, vecs4[i].b, lat);
      chk($sformatf("lat4[%0d]", i), 64'(lat), 64'd4);
      chk($sformatf("sum4[%0d]", i), rsp_sum, vecs4[i].sum);
      chk($sformatf("cout4[%0d]", i), 64'(rsp_cout), 64'(vecs4[i].cout));
      chk($sformatf("ovf4[%0d]", i), 64'(rsp_ovf), 64'(vecs4[i].ovf));
      consume4();
    end

    // Backpressure in DONE with a competing request held
    run_op4(1'b0, 64'h10, 64'h20, lat);
    req_valid = 1'b1; req_a = 64'hAAAA; req_b = 64'h5555; req_sub = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum", rsp_sum, 64'h30);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("bp_exit_valid", 64'(rsp_valid), 64'd0);
    chk("bp_exit_busy", 64'(busy), 64'd0);
    chk("bp_exit_ready", 64'(req_ready), 64'd1);
    chk("bp_retained_sum", rsp_sum, 64'h30);
    @(negedge clk);

    // Reset while slice 2 is due
    req_sub = 1'b0; req_a = 64'hFFFF_FFFF_FFFF_FFFF; req_b = 64'h1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_valid", 64'(rsp_valid), 64'd0);
    chk("midrun_busy_clr", 64'(busy), 64'd0);
    chk("midrun_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    run_op4(1'b0, 64'h1234, 64'h0001, lat);
    chk("after_rst_lat", 64'(lat), 64'd4);
    chk("after_rst_sum", rsp_sum, 64'h1235);
    chk("after_rst_cout", 64'(rsp_cout), 64'd0);
    consume4();

    // WORDS=1 instance
    for (int i = 0; i < 3; i++) begin
      run_op1(vecs1[i].sub, vecs1[i].a[15:0], vecs1[i].b[15:0], lat);
      chk($sformatf("lat1[%0d]", i), 64'(lat), 64'd1);
      chk($sformatf("sum1[%0d]", i), 64'(rsp_sum_1), vecs1[i].sum);
      chk($sformatf("cout1[%0d]", i), 64'(rsp_cout_1), 64'(vecs1[i].cout));
      chk($sformatf("ovf1[%0d]", i), 64'(rsp_ovf_1), 64'(vecs1[i].ovf));
      rsp_ready_1 = 1'b1;
      @(negedge clk);
      rsp_ready_1 = 1'b0;
      chk("valid_drop1", 64'(rsp_valid_1), 64'd0);
    end

    // req_valid held high while busy: exactly one accept
    acc_before = accepts_1;
    req_sub_1 = 1'b0; req_a_1 = 16'h0100; req_b_1 = 16'h0023; req_valid_1 = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("hold_accepts", 64'(accepts_1 - acc_before), 64'd1);
    chk("hold_valid1", 64'(rsp_valid_1), 64'd1);
    chk("hold_sum1", 64'(rsp_sum_1), 64'h0123);
    chk("hold_ready1", 64'(req_ready_1), 64'd0);
    req_valid_1 = 1'b0;
    rsp_ready_1 = 1'b1;
    @(negedge clk);
    rsp_ready_1 = 1'b0;
    chk("hold_exit_ready1", 64'(req_ready_1), 64'd1);
    chk("hold_accepts_end", 64'(accepts_1 - acc_before), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
